// File: rtl/board_sprite_sequencer_if.sv
// Framebuffer write-port bundle between the sprite sequencer and the writer.
// master drives the beat, slave returns ready.
interface board_sprite_sequencer_if #(
  parameter int COORD_W = 10
);
  logic               wr_valid;
  logic               wr_ready;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [24:0]        wr_row;

  modport master (
    output wr_valid, wr_x, wr_y, wr_row,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_row,
    output wr_ready
  );
endinterface

// File: rtl/board_sprite_sequencer.sv
// Streams the 3x3 board's 25x25 glyphs row by row to the framebuffer writer.
// Optional cursor inversion is enabled by defining CELL_HILITE_EN.
module board_sprite_sequencer #(
  parameter int ORIGIN_X   = 0,
  parameter int ORIGIN_Y   = 0,
  parameter int CELL_PITCH = 27,
  parameter int COORD_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [17:0] board_state,
`ifdef CELL_HILITE_EN
  input  logic [3:0]  hilite_cell,
`endif
  output logic [4:0]  shape_row,
  input  logic [24:0] xrow_in,
  input  logic [24:0] orow_in,
  board_sprite_sequencer_if.master wr,
  output logic        busy,
  output logic        done,
  output logic        bad_code
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DONE
  } state_t;

  state_t       state;
  logic [17:0]  snap;
  logic [3:0]   c;
  logic [4:0]   r;
  logic [1:0]   cx;
  logic [1:0]   cy;
  logic [1:0]   code;
  logic [24:0]  glyph;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;

`ifdef CELL_HILITE_EN
  logic [3:0]   hl;
`endif

  assign shape_row = r;

  always_comb begin
    code  = snap[{c, 1'b0} +: 2];
    glyph = '1;
    unique case (1'b1)
      code == 2'b01: glyph = xrow_in;
      code == 2'b10: glyph = orow_in;
      default:       glyph = '1;
    endcase
`ifdef CELL_HILITE_EN
    if (hl == c) glyph = glyph ^ '1;
`endif
    nx = COORD_W'(ORIGIN_X)
       + COORD_W'(cx) * COORD_W'(CELL_PITCH);
    ny = COORD_W'(ORIGIN_Y)
       + COORD_W'(cy) * COORD_W'(CELL_PITCH)
       + COORD_W'(r);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap        <= '0;
      c           <= '0;
      r           <= '0;
      cx          <= '0;
      cy          <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_x     <= '0;
      wr.wr_y     <= '0;
      wr.wr_row   <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      bad_code    <= 1'b0;
`ifdef CELL_HILITE_EN
      hl          <= '1;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            snap  <= board_state;
`ifdef CELL_HILITE_EN
            hl    <= hilite_cell;
`endif
            c     <= '0;
            r     <= '0;
            cx    <= '0;
            cy    <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          wr.wr_row   <= glyph;
          wr.wr_x     <= nx;
          wr.wr_y     <= ny;
          wr.wr_valid <= 1'b1;
          if (code == 2'b11) bad_code <= 1'b1;
          state <= VALID;
        end
        VALID: begin
          if (wr.wr_ready) begin
            wr.wr_valid <= 1'b0;
            if (r < 5'd24) begin
              r     <= r + 5'd1;
              state <= FETCH;
            end else if (c < 4'd8) begin
              r <= '0;
              c <= c + 4'd1;
              // column/row of the cell grid track c without a divider
              if (cx == 2'd2) begin
                cx <= '0;
                cy <= cy + 2'd1;
              end else begin
                cx <= cx + 2'd1;
              end
              state <= FETCH;
            end else begin
              r     <= '0;
              c     <= '0;
              cx    <= '0;
              cy    <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_sprite_sequencer.sv
// Self-checking bench: table of renders plus random renders against a
// beat-list model built from the cell/row rules.
module tb_board_sprite_sequencer;

  localparam int CW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [17:0] board_state;
  logic [3:0]  hilite_cell;
  logic [4:0]  shape_row;
  logic [24:0] xrow_in;
  logic [24:0] orow_in;
  logic        busy;
  logic        done;
  logic        bad_code;

  int vectors = 0;
  int miscompares = 0;
  bit bad_sticky = 1'b0;

  board_sprite_sequencer_if #(.COORD_W(CW)) wr ();

  board_sprite_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .board_state(board_state),
`ifdef CELL_HILITE_EN
    .hilite_cell(hilite_cell),
`endif
    .shape_row  (shape_row),
    .xrow_in    (xrow_in),
    .orow_in    (orow_in),
    .wr         (wr.master),
    .busy       (busy),
    .done       (done),
    .bad_code   (bad_code)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] xrom(input int rr);
    logic [4:0] r5;
    r5 = 5'(rr);
    return {20'hFFFFF, r5};
  endfunction

  function automatic logic [24:0] orom(input int rr);
    logic [4:0] r5;
    r5 = 5'(rr);
    return {~r5, 20'h5A5A5};
  endfunction

  assign xrow_in = xrom(int'(shape_row));
  assign orow_in = orom(int'(shape_row));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit any11(input logic [17:0] bs, input int upto);
    for (int k = 0; k <= upto; k++)
      if (bs[2*k +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a negedge; start is presented in "cycle 0".
  task automatic render(input logic [17:0] bs, input logic [3:0] hl,
                        input int stall_beat, input int stall_len,
                        input bit rnd_ready, input bit restart,
                        input int exp_done, input int exp_bad,
                        input int abort_beat);
    logic [24:0] er[225];
    int ex[225];
    int ey[225];
    int b = 0;
    int next_valid = 2;
    int last_acc = -10;
    int stall_left = stall_len;
    int upto;
    bit fin = 1'b0;
    bit prev_bad = bad_sticky;
    bit ev;
    for (int cc = 0; cc < 9; cc++) begin
      for (int rr = 0; rr < 25; rr++) begin
        int i = cc * 25 + rr;
        case (bs[2*cc +: 2])
          2'b01:   er[i] = xrom(rr);
          2'b10:   er[i] = orom(rr);
          default: er[i] = 25'h1FFFFFF;
        endcase
`ifdef CELL_HILITE_EN
        if (int'(hl) == cc) er[i] = er[i] ^ 25'h1FFFFFF;
`endif
        ex[i] = (cc % 3) * 27;
        ey[i] = (cc / 3) * 27 + rr;
      end
    end
    board_state = bs;
    hilite_cell = hl;
    start = 1'b1;
    wr.wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      if (restart && cyc == 100) start = 1'b1;
      if (restart && cyc == 101) begin
        start = 1'b0;
        board_state = ~bs;
        hilite_cell = ~hl;
      end
      ev = (b < 225) && (cyc >= next_valid);
      if (abort_beat >= 0 && ev && b == abort_beat) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_valid", 64'(wr.wr_valid), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_bad", 64'(bad_code), 0);
        chk("abort_x", 64'(wr.wr_x), 0);
        chk("abort_row", 64'(wr.wr_row), 64'h1FFFFFF);
        chk("abort_srow", 64'(shape_row), 0);
        bad_sticky = 1'b0;
        return;
      end
      if (rnd_ready)
        wr.wr_ready = ($urandom_range(0, 3) != 0);
      else if (ev && b == stall_beat && stall_left > 0) begin
        wr.wr_ready = 1'b0;
        stall_left--;
      end else
        wr.wr_ready = 1'b1;
      chk("valid", 64'(wr.wr_valid), 64'(ev));
      if (b < 225) begin
        chk("busy", 64'(busy), 1);
        chk("shape_row", 64'(shape_row), 64'(b % 25));
      end
      if (ev) upto = b / 25;
      else if (b > 0) upto = (b - 1) / 25;
      else upto = -1;
      chk("bad_code", 64'(bad_code), 64'(prev_bad | any11(bs, upto)));
      if (ev) begin
        chk("wr_x", 64'(wr.wr_x), 64'(ex[b]));
        chk("wr_y", 64'(wr.wr_y), 64'(ey[b]));
        chk("wr_row", 64'(wr.wr_row), 64'(er[b]));
        if (wr.wr_ready) begin
          b++;
          next_valid = cyc + 2;
          last_acc = cyc;
        end
      end
      chk("done", 64'(done), 64'(b == 225 && cyc == last_acc + 1));
      if (b == 225 && cyc == last_acc + 1) begin
        fin = 1'b1;
        chk("done_busy", 64'(busy), 0);
        if (exp_done > 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
        if (exp_bad >= 0) chk("bad_end", 64'(bad_code), 64'(exp_bad));
      end
      @(negedge clk);
    end
    if (!fin) chk("render_timeout", 0, 1);
    chk("idle_done", 64'(done), 0);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_valid", 64'(wr.wr_valid), 0);
    chk("idle_srow", 64'(shape_row), 0);
    bad_sticky = prev_bad | any11(bs, 8);
  endtask

  typedef struct {
    logic [17:0] bs;
    int          stall_beat;
    int          stall_len;
    bit          restart;
    int          exp_done;
    int          exp_bad;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{18'h00000, -1, 0, 1'b0, 451, 0};
    tbl[1] = '{18'h00100, -1, 0, 1'b0, 451, 0};
    tbl[2] = '{18'h00002,  3, 5, 1'b0, 456, 0};
    tbl[3] = '{18'h24918, -1, 0, 1'b1, 451, 0};
    tbl[4] = '{18'h00030, -1, 0, 1'b0, 451, 1};
    tbl[5] = '{18'h24918, 10, 2, 1'b0, 453, 1};

    rst_n = 1'b0;
    start = 1'b0;
    board_state = '0;
    hilite_cell = 4'hF;
    wr.wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(wr.wr_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_bad", 64'(bad_code), 0);
    chk("rst_x", 64'(wr.wr_x), 0);
    chk("rst_y", 64'(wr.wr_y), 0);
    chk("rst_row", 64'(wr.wr_row), 64'h1FFFFFF);
    chk("rst_srow", 64'(shape_row), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      render(tbl[i].bs, 4'hF, tbl[i].stall_beat, tbl[i].stall_len,
             1'b0, tbl[i].restart, tbl[i].exp_done, tbl[i].exp_bad, -1);
      repeat (2) @(negedge clk);
    end

    // reset during cell 5, then a fresh render from cell 0 row 0
    render(18'h00100, 4'hF, -1, 0, 1'b0, 1'b0, 0, -1, 128);
    @(negedge clk);
    render(18'h00000, 4'hF, -1, 0, 1'b0, 1'b0, 451, 0, -1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      logic [17:0] rb;
      logic [3:0]  rh;
      rb = 18'($urandom);
      rh = 4'($urandom_range(0, 15));
      render(rb, rh, -1, 0, 1'b1, 1'b0, 0, -1, -1);
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_sprite_sequencer.md
Name: board_sprite_sequencer

Overview:
- Walks the 3x3 tic-tac-toe board and streams each cell's 25x25 glyph (X, O or blank) row by row into the framebuffer write port.
- Drives a row index to the combinational X/O shape ROMs, registers the selected row, and presents it with a valid/ready handshake.
- Sits between the game-state register and the framebuffer writer.
- Started once per board update.

Parameters:
- ORIGIN_X, 0: pixel x of top-left corner of cell 0.
- ORIGIN_Y, 0: pixel y of top-left corner of cell 0.
- CELL_PITCH, 27: pixel distance between cell origins (25 px glyph + 2 px grid line).
- COORD_W, 10: width of wr_x / wr_y.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to render the board; honoured only in IDLE.
- board_state  in  18  two bits per cell, cell c at [2c+1:2c]; cells numbered row-major 0..8; 00 empty, 01 X, 10 O, 11 reserved.
- shape_row  out  5  row index (0..24) driven to both shape ROMs.
- xrow_in  in  25  X ROM row at shape_row; bit value 0 = ink.
- orow_in  in  25  O ROM row at shape_row; bit value 0 = ink.
- wr_valid  out  1  write beat present.
- wr_ready  in  1  framebuffer accepts beat.
- wr_x  out  COORD_W  pixel x of row's leftmost pixel.
- wr_y  out  COORD_W  pixel y of row.
- wr_row  out  25  row pixels, 0 = ink, 1 = background.
- busy  out  1  render in progress.
- done  out  1  one-cycle pulse after last beat accepted.
- bad_code  out  1  sticky: a reserved code 11 was seen in the current or a previous render.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Next state IDLE.
  - wr_valid=0, busy=0, done=0.
  - wr_x=0, wr_y=0, wr_row=25'h1FFFFFF, shape_row=0, bad_code=0.
  - Cell and row counters are cleared.
  - Reset mid-render aborts immediately; no further beats are issued.
- States: IDLE, FETCH, VALID, DONE.
- IDLE -> FETCH:
  - Taken on start=1.
  - board_state is snapshotted into an internal register; later changes to board_state do not affect this render.
  - cell counter c=0, row counter r=0.
- FETCH (1 cycle):
  - shape_row = r.
  - wr_row is registered as xrow_in for code 01, orow_in for code 10, 25'h1FFFFFF for codes 00 and 11.
  - Code 11 sets bad_code.
  - Registered positions: wr_x = ORIGIN_X + (c mod 3)*CELL_PITCH, wr_y = ORIGIN_Y + (c div 3)*CELL_PITCH + r.
  - Positions are computed in COORD_W bits; overflow truncates.
  - Next state VALID.
- VALID:
  - wr_valid=1.
  - wr_x, wr_y and wr_row are held stable while wr_ready=0.
  - On wr_valid & wr_ready:
    - If r<24: r++, go to FETCH.
    - Else if c<8: r=0, c++, go to FETCH.
    - Else (c=8, r=24): go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- busy=1 in FETCH and VALID only.
- start is ignored outside IDLE; no queuing.
- start in the DONE cycle is ignored.
- Timing with wr_ready held high:
  - start sampled at edge 0.
  - Row k (0..224) is valid in cycle 2+2k.
  - done is high in cycle 451.
- Each wr_ready=0 cycle during VALID delays done by one cycle.
- Beat order: cell 0 rows 0..24, then cell 1, ... cell 8; 225 beats per render.
- shape_row equals r at all times; it is 0 in IDLE.

Optional Feature:
- CELL_HILITE_EN defined:
  - Adds input hilite_cell [3:0], sampled with the board snapshot at start.
  - If hilite_cell = c (0..8), every wr_row of cell c is inverted (bitwise XOR 25'h1FFFFFF) to show the cursor.
  - Values 9..15 highlight nothing.
- CELL_HILITE_EN undefined: port absent; no inversion.

Test Plan:
- Empty board (18'h0), wr_ready=1, start pulse -> 225 beats, all wr_row=25'h1FFFFFF; first beat wr_x=0, wr_y=0; last beat wr_x=54, wr_y=78; done high in cycle 451 only.
- board_state=18'h00100 (X in cell 4), stub X ROM returns {20'hFFFFF, shape_row} -> cell 4 beats at wr_x=27, wr_y=27..51, wr_row={20'hFFFFF, r}; all other cells blank; bad_code=0.
- O in cell 0, wr_ready low 5 cycles while cell 0 row 3 is valid -> wr_x=0, wr_y=3 and wr_row stable for 6 cycles, no beat duplicated or dropped; done in cycle 456.
- Second start pulse at cycle 100 and board_state changed at cycle 101 -> ignored; beat sequence matches the original snapshot; exactly 225 beats.
- rst_n low for 1 cycle during cell 5 -> next cycle wr_valid=0, busy=0; a new start restarts at cell 0 row 0 with wr_x=0, wr_y=0.
- Cell 2 code 11 -> cell 2 renders blank; bad_code rises during cell 2 FETCH and stays 1 across the next render until reset.
